execute_muldiv_stage: RTL

EXECUTE_MULDIV_STAGE -- requirements
Module: execute_muldiv_stage

---
 rtl/execute_muldiv_stage_pkg.sv | 40 ++++
 rtl/execute_muldiv_stage_muldiv.sv | 115 +++++++++++
 rtl/execute_muldiv_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/execute_muldiv_stage_pkg.sv
// Shared types and encodings for the execute stage and its multiply/divide engine.
package common;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_t alu_op;
  } control_type;

  // Store widths (funct3 of STORE opcode)
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  // M-extension operations (funct3 of OP opcode, funct7 = 0000001)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/execute_muldiv_stage_muldiv.sv
// Iterative multiply/divide engine: one bit per cycle on operand magnitudes,
// sign applied when the result is read in DONE.
module muldiv_unit
  import common::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output muldiv_state_t   o_state,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);

  muldiv_state_t   r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_d;
  logic [2:0]      r_op;
  logic            r_neg, r_rneg;

  logic            w_is_div, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  // Operand sign decode and magnitudes at accept
  always_comb begin
    w_is_div = i_op[2];
    w_a_neg  = i_a[XLEN-1] & (w_is_div ? !i_op[0] : (i_op == F3_MULH || i_op == F3_MULHSU));
    w_b_neg  = i_b[XLEN-1] & (w_is_div ? !i_op[0] : (i_op == F3_MULH));
    w_a_mag  = w_a_neg ? -i_a : i_a;
    w_b_mag  = w_b_neg ? -i_b : i_b;
  end

  // Single iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_d};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = BUSY;
      BUSY:    if (i_flush) w_next = IDLE;
               else if (r_cnt == CW'(XLEN - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and per-cycle iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_d    <= '0;
      r_op   <= '0;
      r_neg  <= 1'b0;
      r_rneg <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= w_a_mag;
      r_d    <= w_b_mag;
      r_op   <= i_op;
      // A zero divisor must yield an all-ones quotient regardless of dividend sign
      r_neg  <= (w_a_neg ^ w_b_neg) && !(w_is_div && i_b == '0);
      r_rneg <= w_a_neg;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_op[2]) begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end else if (!w_diff[XLEN]) begin
        r_hi <= w_diff[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b1};
      end else begin
        r_hi <= w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Outputs: state flags and sign-corrected result selection
  always_comb begin
    o_state  = r_state;
    o_done   = (r_state == DONE);
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg ? -w_prod : w_prod;
    case (r_op)
      F3_MUL:                       o_result = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              o_result = r_neg ? -r_lo : r_lo;
      default:                      o_result = r_rneg ? -r_hi : r_hi;
    endcase
  end

endmodule

// File: rtl/execute_muldiv_stage.sv
// EX stage: forwarding muxes, single-cycle ALU, store lane alignment, and
// hand-off of M-extension ops to the iterative muldiv_unit.
module execute_muldiv_stage
  import common::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] immediate_data,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] fwd_data_ex_mem,
  input  logic [XLEN-1:0] fwd_data_mem_wb,
  input  logic [2:0]      func3,
  input  control_type     control_in,
  input  logic            is_muldiv,
  input  logic            in_valid,
  input  logic            flush,
  output control_type     control_out,
  output logic [XLEN-1:0] alu_data,
  output logic [XLEN-1:0] memory_data,
  output logic            out_valid,
  output logic            busy
);

  localparam int unsigned LB  = $clog2(XLEN / 8);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [LB+2:0] SH_MASK = (LB + 3)'(8);
  localparam logic [LB+2:0] SW_MASK = (LB + 3)'(24);

  logic [XLEN-1:0] w_left, w_rs2, w_right, w_alu, w_mem, w_md_result;
  logic [LB+2:0]   w_boff;
  muldiv_state_t   w_md_state;
  logic            w_md_done, w_accept;
  control_type     r_ctrl;

  // Forwarding and immediate operand selection
  always_comb begin
    case (forward_a)
      2'b10:   w_left = fwd_data_ex_mem;
      2'b01:   w_left = fwd_data_mem_wb;
      default: w_left = data1;
    endcase
    case (forward_b)
      2'b10:   w_rs2 = fwd_data_ex_mem;
      2'b01:   w_rs2 = fwd_data_mem_wb;
      default: w_rs2 = data2;
    endcase
    w_right = control_in.alu_src ? immediate_data : w_rs2;
  end

  // Single-cycle ALU
  always_comb begin
    case (control_in.alu_op)
      ALU_ADD:  w_alu = w_left + w_right;
      ALU_SUB:  w_alu = w_left - w_right;
      ALU_AND:  w_alu = w_left & w_right;
      ALU_OR:   w_alu = w_left | w_right;
      ALU_XOR:  w_alu = w_left ^ w_right;
      ALU_SLL:  w_alu = w_left << w_right[SHW-1:0];
      ALU_SRL:  w_alu = w_left >> w_right[SHW-1:0];
      ALU_SRA:  w_alu = $signed(w_left) >>> w_right[SHW-1:0];
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_left) < $signed(w_right)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_left < w_right};
      default:  w_alu = '0;
    endcase
  end

  // Store data placed in the lane selected by the low address bits
  always_comb begin
    w_boff = {w_alu[LB-1:0], 3'b000};
    case (func3)
      F3_SB:   w_mem = XLEN'(w_rs2[7:0]) << w_boff;
      F3_SH:   w_mem = XLEN'(w_rs2[15:0]) << (w_boff & ~SH_MASK);
      F3_SW:   w_mem = (XLEN == 64) ? XLEN'(w_rs2[31:0]) << (w_boff & ~SW_MASK) : w_rs2;
      default: w_mem = w_rs2;
    endcase
  end

  assign w_accept = in_valid && is_muldiv && !flush && (w_md_state == IDLE);

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_flush  (flush),
    .i_op     (func3),
    .i_a      (w_left),
    .i_b      (w_right),
    .o_state  (w_md_state),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Hold the M op's control word until its result retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_ctrl <= '0;
    else if (w_accept) r_ctrl <= control_in;
  end

  // Result steering, valid and stall generation
  always_comb begin
    memory_data = w_mem;
    alu_data    = w_md_done ? w_md_result : w_alu;
    control_out = reset ? '0 : (w_md_done ? r_ctrl : control_in);
    out_valid   = !reset && (w_md_done ? !flush
                                       : (w_md_state == IDLE && in_valid && !is_muldiv));
    busy        = !reset && (w_accept || w_md_state == BUSY);
  end

endmodule
